// File: rtl/hex_display_scanner_pkg.sv
// -----------------------------------------------------------------------------
// hex_display_scanner_pkg
// Shared definitions for the hex display scan controller:
//   - state_e           : scan FSM states (IDLE, BLANK, SHOW)
//   - DEFAULT_PRESCALE  : default clk cycles per digit slot
//   - DEFAULT_BLANK_CYCLES : default blanking cycles at the start of a slot
//   - slot_cnt_width()  : width of a counter that spans 0..PRESCALE-1
// -----------------------------------------------------------------------------
package hex_display_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  localparam int DEFAULT_PRESCALE     = 50000;
  localparam int DEFAULT_BLANK_CYCLES = 16;

  // Counter width needed to count 0..prescale-1, never narrower than 1 bit.
  function automatic int slot_cnt_width(input int prescale);
    int w;
    w = $clog2(prescale);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/hex_display_scanner_scan_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
// Slot counter for the display scanner. Counts 0..PRESCALE-1 and wraps; a
// clear input forces it back to 0 on the next edge.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : synchronous clear (counter = 0 next cycle)
//   blank_done  : high on the last blanking cycle of a slot
//   slot_done   : high on the last cycle of a slot
// -----------------------------------------------------------------------------
module scan_prescaler
  import hex_display_scanner_pkg::*;
#(
  parameter int PRESCALE     = DEFAULT_PRESCALE,
  parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES,
  localparam int CNT_W       = slot_cnt_width(PRESCALE)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic blank_done,
  output logic slot_done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Pulse decode from the current count.
  always_comb begin
    blank_done = (cnt_q == CNT_W'(BLANK_CYCLES - 1));
    slot_done  = (cnt_q == CNT_W'(PRESCALE - 1));
  end

  // Next count: clear wins, otherwise wrap at the end of the slot.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (slot_done) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hex_display_scanner.sv
// -----------------------------------------------------------------------------
// hex_display_scanner
// Time-multiplexed scan controller feeding a seven-segment decoder. A packed
// hex value is loaded over valid/ready into a pending register and moved into
// the display register either immediately (when idle) or at a frame boundary,
// so a frame never mixes two values. Each digit slot starts with a blanking
// gap (all anodes off) followed by the show phase.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   enable       : scan enable; low forces IDLE with all digits off
//   load_valid   : load_data offered
//   load_ready   : registered; high when the pending register is empty
//   load_data    : packed value, digit 0 in bits [3:0]
//   digit_data   : nibble of the selected digit
//   digit_an     : active-low digit enables (one-hot-low or all ones)
//   digit_idx    : index of the selected digit
// Optional feature: define LEADING_ZERO_BLANK_EN to keep leading zero digits
// dark during their show phase (digit 0 always lit).
// -----------------------------------------------------------------------------
module hex_display_scanner
  import hex_display_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = DEFAULT_PRESCALE,
  parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES,
  localparam int IDX_W       = $clog2(NUM_DIGITS),
  localparam int DATA_W      = 4 * NUM_DIGITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  output logic [3:0]        digit_data,
  output logic [NUM_DIGITS-1:0] digit_an,
  output logic [IDX_W-1:0]  digit_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [3:0]              data_q, data_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    load_ready_q, load_ready_d;
  logic [DATA_W-1:0]       display_q, display_d;
  logic [DATA_W-1:0]       pending_q, pending_d;
  logic                    pend_valid_q, pend_valid_d;

  logic clear_s;
  logic blank_done_s;
  logic slot_done_s;
  logic take_s;
  logic boundary_s;
  logic consume_s;
  logic lit_s;

  scan_prescaler #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear_s),
    .blank_done (blank_done_s),
    .slot_done  (slot_done_s)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is lit if it is digit 0 or any nibble at or above it is non-zero.
  function automatic logic digit_lit(input logic [DATA_W-1:0] value,
                                     input logic [IDX_W-1:0]  idx);
    logic lit;
    lit = (idx == '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IDX_W'(i) >= idx) && (value[4*i +: 4] != 4'h0)) begin
        lit = 1'b1;
      end else begin
        lit = lit;
      end
    end
    return lit;
  endfunction
`endif

  // Handshake and frame-boundary decode; the counter is held at 0 while idle
  // so the first slot after enable has full length.
  always_comb begin
    take_s     = load_valid && load_ready_q;
    boundary_s = enable && (state_q == ST_SHOW) && slot_done_s && (idx_q == LAST_IDX);
    consume_s  = pend_valid_q && ((state_q == ST_IDLE) || boundary_s);
    clear_s    = !enable || (state_q == ST_IDLE);
  end

  // Pending/display registers: a consume moves the old pending value first,
  // then a same-cycle capture refills pending.
  always_comb begin
    display_d    = display_q;
    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;
    if (consume_s) begin
      display_d    = pending_q;
      pend_valid_d = 1'b0;
    end else begin
      display_d    = display_q;
    end
    if (take_s) begin
      pending_d    = load_data;
      pend_valid_d = 1'b1;
    end else begin
      pending_d    = pending_q;
    end
    load_ready_d = ~pend_valid_d;
  end

  // Scan FSM next state, digit index and nibble (nibble latched on BLANK entry).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          idx_d   = '0;
        end
        ST_BLANK: begin
          if (blank_done_s) begin
            state_d = ST_SHOW;
          end else begin
            state_d = ST_BLANK;
          end
        end
        ST_SHOW: begin
          if (slot_done_s) begin
            state_d = ST_BLANK;
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            state_d = ST_SHOW;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      endcase
      if ((state_d == ST_BLANK) && (state_q != ST_BLANK)) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (IDX_W'(i) == idx_d) begin
            data_d = display_d[4*i +: 4];
          end else begin
            data_d = data_d;
          end
        end
      end else begin
        data_d = data_q;
      end
    end
  end

  // Anode drive: one-hot-low only in SHOW of a lit digit.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    lit_s = digit_lit(display_d, idx_d);
`else
    lit_s = 1'b1;
`endif
    an_d = '1;
    if ((state_d == ST_SHOW) && lit_s) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (IDX_W'(i) == idx_d) begin
          an_d[i] = 1'b0;
        end else begin
          an_d[i] = 1'b1;
        end
      end
    end else begin
      an_d = '1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      data_q       <= 4'h0;
      an_q         <= '1;
      load_ready_q <= 1'b1;
      display_q    <= '0;
      pending_q    <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      an_q         <= an_d;
      load_ready_q <= load_ready_d;
      display_q    <= display_d;
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign load_ready = load_ready_q;
  assign digit_data = data_q;
  assign digit_an   = an_q;
  assign digit_idx  = idx_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_hex_display_scanner
// Directed and randomized stimulus for hex_display_scanner (NUM_DIGITS=4,
// PRESCALE=8, BLANK_CYCLES=2). Expected outputs come from a timeline model:
// time since enable gives slot, digit and phase by division; loads go into a
// one-deep pending slot released when idle or at frame boundaries.
// -----------------------------------------------------------------------------
module tb_hex_display_scanner;

  localparam int N = 4;
  localparam int P = 8;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  digit_data;
  logic [3:0]  digit_an;
  logic [1:0]  digit_idx;

  int vectors     = 0;
  int miscompares = 0;

  // Model state
  bit          running;
  int          t;
  int          slot_m;
  logic [15:0] disp_m;
  logic [15:0] pend_m;
  bit          pv_m;
  logic        ready_m;
  logic [3:0]  data_m;
  logic [3:0]  an_m;
  logic [1:0]  idx_m;

  hex_display_scanner #(
    .NUM_DIGITS   (N),
    .PRESCALE     (P),
    .BLANK_CYCLES (B)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .digit_data (digit_data),
    .digit_an   (digit_an),
    .digit_idx  (digit_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] nib(input logic [15:0] v, input int d);
    return v[4*d +: 4];
  endfunction

  function automatic bit lit(input logic [15:0] v, input int d);
`ifdef LEADING_ZERO_BLANK_EN
    return (d == 0) || ((v >> (4 * d)) != 16'h0);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    running = 0; t = 0; slot_m = 0;
    disp_m = 16'h0; pend_m = 16'h0; pv_m = 0; ready_m = 1'b1;
    data_m = 4'h0; an_m = 4'hF; idx_m = 2'd0;
  endtask

  task automatic model_edge();
    bit was_running;
    bit take;
    bit consume;
    was_running = running;
    take = load_valid && ready_m;
    if (!enable) running = 0;
    else if (!running) begin running = 1; t = 0; end
    else t = t + 1;
    consume = pv_m && (!was_running || (enable && (t % (N * P) == 0)));
    if (consume) begin disp_m = pend_m; pv_m = 0; end
    if (take) begin pend_m = load_data; pv_m = 1; end
    ready_m = !pv_m;
    if (running) begin
      slot_m = (t / P) % N;
      idx_m  = 2'(slot_m);
      data_m = nib(disp_m, slot_m);
      an_m   = 4'hF;
      if ((t % P) >= B && lit(disp_m, slot_m)) an_m[slot_m] = 1'b0;
    end else begin
      an_m  = 4'hF;
      idx_m = 2'd0;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("load_ready", {15'd0, load_ready}, {15'd0, ready_m});
    chk("digit_an",   {12'd0, digit_an},   {12'd0, an_m});
    chk("digit_data", {12'd0, digit_data}, {12'd0, data_m});
    chk("digit_idx",  {14'd0, digit_idx},  {14'd0, idx_m});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic offer(input logic [15:0] v);
    load_valid = 1'b1;
    load_data  = v;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; load_valid = 1'b0; load_data = 16'h0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b0;
    tick();

    // Plain scan of an all-zero value
    enable = 1'b1;
    run(40);

    // Load while idle, then scan
    enable = 1'b0;
    tick();
    offer(16'hA3F0);
    run(2);
    enable = 1'b1;
    run(34);

    // Load during digit 1; a second offer while pending is full is refused
    for (int k = 0; k < 64 && !(running && slot_m == 1); k++) tick();
    offer(16'h1234);
    offer(16'hBEEF);
    run(40);

    // Drop enable in SHOW of digit 2, then re-enable
    for (int k = 0; k < 64 && !(running && slot_m == 2 && (t % P) >= B); k++) tick();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    run(20);

    // Leading-zero patterns
    offer(16'h0050);
    run(72);
    offer(16'h0000);
    run(72);

    // Asynchronous reset mid-frame with a pending value
    offer(16'h5A5A);
    run(3);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    run(20);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = 16'($urandom);
      if (enable) enable = ($urandom_range(0, 99) >= 2);
      else        enable = ($urandom_range(0, 9) >= 3);
      tick();
    end
    load_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
